// File: rtl/btle_tx_pdu_serializer_if.sv
// Link-layer <-> serializer bundle: packet parameters, PDU buffer write port,
// start/busy/done handshake and the timed air-bit stream.
interface btle_tx_pdu_serializer_if #(
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6
);
    logic [7:0]                          preamble;
    logic [31:0]                         access_address;
    logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number;
    logic                                pdu_octet_mem_we;
    logic [5:0]                          pdu_octet_mem_addr;
    logic [7:0]                          pdu_octet_mem_data;
    logic                                start;
    logic                                busy;
    logic                                bit_out;
    logic                                bit_valid;
    logic                                bit_last;
    logic                                done;

    modport master (
        output preamble, access_address, crc_state_init_bit, channel_number,
        output pdu_octet_mem_we, pdu_octet_mem_addr, pdu_octet_mem_data, start,
        input  busy, bit_out, bit_valid, bit_last, done
    );

    modport slave (
        input  preamble, access_address, crc_state_init_bit, channel_number,
        input  pdu_octet_mem_we, pdu_octet_mem_addr, pdu_octet_mem_data, start,
        output busy, bit_out, bit_valid, bit_last, done
    );
endinterface

// File: rtl/btle_tx_pdu_serializer.sv
// BLE TX packet serializer: preamble, access address, whitened PDU and
// whitened CRC24, one air bit every SAMPLE_PER_SYMBOL clocks.
module btle_tx_pdu_serializer #(
    parameter int SAMPLE_PER_SYMBOL        = 16,
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int MAX_PAYLOAD_LEN          = 62
) (
    input  logic                   clk,
    input  logic                   rst,
    btle_tx_pdu_serializer_if.slave bus
);
    localparam int SPS_W = (SAMPLE_PER_SYMBOL > 1) ? $clog2(SAMPLE_PER_SYMBOL) : 1;
    localparam logic [SPS_W-1:0] SPS_LAST = SPS_W'(SAMPLE_PER_SYMBOL - 1);
    localparam int CW = CRC_STATE_BIT_WIDTH;
    localparam logic [CW-1:0] CRC_POLY = CW'(24'h00065A);
    localparam logic [8:0]    CRC_LAST_IDX = 9'(CW - 1);
    localparam logic [7:0]    MAX_LEN = 8'(MAX_PAYLOAD_LEN);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PREAMBLE    = 3'd1,
        ST_ACCESS_ADDR = 3'd2,
        ST_PDU         = 3'd3,
        ST_CRC         = 3'd4
    } state_t;

    function automatic logic [CW-1:0] crc_step(input logic [CW-1:0] c, input logic d);
        logic fb;
        fb = c[CW-1] ^ d;
        crc_step = {c[CW-2:0], fb} ^ (fb ? CRC_POLY : {CW{1'b0}});
    endfunction

    function automatic logic [6:0] whiten_step(input logic [6:0] w);
        whiten_step = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
    endfunction

    // Channel bits enter the LFSR bit-reversed below the constant 1 in w[6].
    function automatic logic [6:0] whiten_seed(input logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] ch);
        whiten_seed = {1'b1, ch[0], ch[1], ch[2], ch[3], ch[4], ch[5]};
    endfunction

    logic [7:0]       pdu_mem_r [64];
    state_t           state_r, state_nxt_s;
    logic [SPS_W-1:0] sps_cnt_r, sps_cnt_nxt_s;
    logic [8:0]       bit_idx_r, bit_idx_nxt_s;
    logic [8:0]       pdu_last_idx_r, pdu_last_idx_nxt_s;
    logic [7:0]       preamble_r, preamble_nxt_s;
    logic [31:0]      aa_r, aa_nxt_s;
    logic [CW-1:0]    crc_r, crc_nxt_s;
    logic [6:0]       wh_r, wh_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             bit_out_r, bit_out_nxt_s;
    logic             bit_valid_r, bit_valid_nxt_s;
    logic             bit_last_r, bit_last_nxt_s;
    logic             done_r, done_nxt_s;
    logic [7:0]       len_s;
    logic [8:0]       pdu_next_idx_s;
    logic             pdu_raw_s;
    logic             period_end_s;

    // PDU buffer: link-layer writes land only while no packet is in flight.
    always_ff @(posedge clk) begin
        if (bus.pdu_octet_mem_we && !busy_r) begin
            pdu_mem_r[bus.pdu_octet_mem_addr] <= bus.pdu_octet_mem_data;
        end
    end

    // Clamped length and the unwhitened PDU bit that would be sent next.
    always_comb begin
        len_s = (pdu_mem_r[1] > MAX_LEN) ? MAX_LEN : pdu_mem_r[1];
        if (state_r == ST_PDU) begin
            pdu_next_idx_s = bit_idx_r + 9'd1;
        end else begin
            pdu_next_idx_s = 9'd0;
        end
        pdu_raw_s    = pdu_mem_r[pdu_next_idx_s[8:3]][pdu_next_idx_s[2:0]];
        period_end_s = (sps_cnt_r == SPS_LAST);
    end

    // Next-state and next-output logic; each new bit is produced at a period boundary.
    always_comb begin
        state_nxt_s        = state_r;
        sps_cnt_nxt_s      = sps_cnt_r;
        bit_idx_nxt_s      = bit_idx_r;
        pdu_last_idx_nxt_s = pdu_last_idx_r;
        preamble_nxt_s     = preamble_r;
        aa_nxt_s           = aa_r;
        crc_nxt_s          = crc_r;
        wh_nxt_s           = wh_r;
        busy_nxt_s         = busy_r;
        bit_out_nxt_s      = bit_out_r;
        bit_valid_nxt_s    = 1'b0;
        bit_last_nxt_s     = 1'b0;
        done_nxt_s         = 1'b0;

        if (state_r != ST_IDLE) begin
            sps_cnt_nxt_s = period_end_s ? {SPS_W{1'b0}} : sps_cnt_r + {{(SPS_W-1){1'b0}}, 1'b1};
        end else begin
            sps_cnt_nxt_s = {SPS_W{1'b0}};
        end

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s        = ST_PREAMBLE;
                    bit_idx_nxt_s      = 9'd0;
                    pdu_last_idx_nxt_s = 9'({len_s, 3'b000}) + 9'd15;
                    preamble_nxt_s     = bus.preamble;
                    aa_nxt_s           = bus.access_address;
                    crc_nxt_s          = bus.crc_state_init_bit;
                    wh_nxt_s           = whiten_seed(bus.channel_number);
                    busy_nxt_s         = 1'b1;
                    bit_out_nxt_s      = bus.preamble[0];
                    bit_valid_nxt_s    = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ST_PREAMBLE: begin
                if (period_end_s) begin
                    bit_valid_nxt_s = 1'b1;
                    if (bit_idx_r == 9'd7) begin
                        state_nxt_s   = ST_ACCESS_ADDR;
                        bit_idx_nxt_s = 9'd0;
                        bit_out_nxt_s = aa_r[0];
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 9'd1;
                        bit_out_nxt_s = preamble_r[bit_idx_r[2:0] + 3'd1];
                    end
                end else begin
                    bit_valid_nxt_s = 1'b0;
                end
            end
            ST_ACCESS_ADDR: begin
                if (period_end_s) begin
                    bit_valid_nxt_s = 1'b1;
                    if (bit_idx_r == 9'd31) begin
                        state_nxt_s   = ST_PDU;
                        bit_idx_nxt_s = 9'd0;
                        bit_out_nxt_s = pdu_raw_s ^ wh_r[6];
                        crc_nxt_s     = crc_step(crc_r, pdu_raw_s);
                        wh_nxt_s      = whiten_step(wh_r);
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 9'd1;
                        bit_out_nxt_s = aa_r[bit_idx_r[4:0] + 5'd1];
                    end
                end else begin
                    bit_valid_nxt_s = 1'b0;
                end
            end
            ST_PDU: begin
                if (period_end_s) begin
                    bit_valid_nxt_s = 1'b1;
                    wh_nxt_s        = whiten_step(wh_r);
                    if (bit_idx_r == pdu_last_idx_r) begin
                        // CRC already holds the final PDU bit; send its MSB first.
                        state_nxt_s   = ST_CRC;
                        bit_idx_nxt_s = 9'd0;
                        bit_out_nxt_s = crc_r[CW-1] ^ wh_r[6];
                        crc_nxt_s     = {crc_r[CW-2:0], 1'b0};
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 9'd1;
                        bit_out_nxt_s = pdu_raw_s ^ wh_r[6];
                        crc_nxt_s     = crc_step(crc_r, pdu_raw_s);
                    end
                end else begin
                    bit_valid_nxt_s = 1'b0;
                end
            end
            ST_CRC: begin
                if (period_end_s) begin
                    if (bit_idx_r == CRC_LAST_IDX) begin
                        state_nxt_s   = ST_IDLE;
                        bit_idx_nxt_s = 9'd0;
                        busy_nxt_s    = 1'b0;
                        done_nxt_s    = 1'b1;
                        bit_out_nxt_s = 1'b0;
                    end else begin
                        bit_valid_nxt_s = 1'b1;
                        bit_last_nxt_s  = (bit_idx_r == CRC_LAST_IDX - 9'd1);
                        bit_idx_nxt_s   = bit_idx_r + 9'd1;
                        bit_out_nxt_s   = crc_r[CW-1] ^ wh_r[6];
                        crc_nxt_s       = {crc_r[CW-2:0], 1'b0};
                        wh_nxt_s        = whiten_step(wh_r);
                    end
                end else begin
                    bit_valid_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                busy_nxt_s    = 1'b0;
                bit_out_nxt_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            sps_cnt_r      <= {SPS_W{1'b0}};
            bit_idx_r      <= 9'd0;
            pdu_last_idx_r <= 9'd0;
            preamble_r     <= 8'd0;
            aa_r           <= 32'd0;
            crc_r          <= {CW{1'b0}};
            wh_r           <= 7'd0;
            busy_r         <= 1'b0;
            bit_out_r      <= 1'b0;
            bit_valid_r    <= 1'b0;
            bit_last_r     <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            sps_cnt_r      <= sps_cnt_nxt_s;
            bit_idx_r      <= bit_idx_nxt_s;
            pdu_last_idx_r <= pdu_last_idx_nxt_s;
            preamble_r     <= preamble_nxt_s;
            aa_r           <= aa_nxt_s;
            crc_r          <= crc_nxt_s;
            wh_r           <= wh_nxt_s;
            busy_r         <= busy_nxt_s;
            bit_out_r      <= bit_out_nxt_s;
            bit_valid_r    <= bit_valid_nxt_s;
            bit_last_r     <= bit_last_nxt_s;
            done_r         <= done_nxt_s;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.bit_out   = bit_out_r;
    assign bus.bit_valid = bit_valid_r;
    assign bus.bit_last  = bit_last_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_btle_tx_pdu_serializer.sv
// Self-checking bench: captures each air packet and compares it with a
// queue-based packet model built from the BLE framing rules.
module tb_btle_tx_pdu_serializer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btle_tx_pdu_serializer_if bus();
    btle_tx_pdu_serializer dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    int pkt_id   = 0;
    logic [7:0] model_mem [64];
    bit exp_q[$];
    bit got_q[$];
    logic [7:0]  nxt_pre;
    logic [31:0] nxt_aa;
    logic [23:0] nxt_crc;
    logic [5:0]  nxt_ch;

    typedef struct {
        logic [7:0]  hdr0;
        logic [7:0]  hdr1;
        logic [7:0]  pre;
        logic [31:0] aa;
        logic [23:0] crc;
        logic [5:0]  ch;
        int          exp_bits;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Whole packet as a bit list: framing, CRC over the PDU, whitening over PDU+CRC.
    function automatic void build_expected(input logic [7:0] pre, input logic [31:0] aa,
                                           input logic [23:0] c0, input logic [5:0] ch);
        int len;
        bit body[$];
        logic [23:0] c;
        logic [6:0] w;
        bit fb, w6;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(pre[i]);
        for (int i = 0; i < 32; i++) exp_q.push_back(aa[i]);
        len = (model_mem[1] > 8'd62) ? 62 : int'(model_mem[1]);
        for (int o = 0; o < 2 + len; o++)
            for (int b = 0; b < 8; b++) body.push_back(model_mem[o][b]);
        c = c0;
        foreach (body[i]) begin
            fb = c[23] ^ body[i];
            c  = {c[22:0], fb} ^ (fb ? 24'h00065A : 24'h000000);
        end
        for (int i = 23; i >= 0; i--) body.push_back(c[i]);
        w = {1'b1, ch[0], ch[1], ch[2], ch[3], ch[4], ch[5]};
        foreach (body[i]) begin
            exp_q.push_back(body[i] ^ w[6]);
            w6 = w[6];
            w  = {w[5:0], w6};
            w[4] = w[4] ^ w6;
        end
    endfunction

    task automatic fill_buffer(input logic [7:0] hdr0, input logic [7:0] hdr1);
        logic [7:0] d;
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            d = (a == 0) ? hdr0 : (a == 1) ? hdr1 : 8'($urandom);
            bus.pdu_octet_mem_we   = 1'b1;
            bus.pdu_octet_mem_addr = 6'(a);
            bus.pdu_octet_mem_data = d;
            model_mem[a] = d;
        end
        @(negedge clk);
        bus.pdu_octet_mem_we = 1'b0;
    endtask

    task automatic write_byte(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.pdu_octet_mem_we   = 1'b1;
        bus.pdu_octet_mem_addr = a;
        bus.pdu_octet_mem_data = d;
        model_mem[a] = d;
        @(negedge clk);
        bus.pdu_octet_mem_we = 1'b0;
    endtask

    task automatic set_params(input logic [7:0] pre, input logic [31:0] aa,
                              input logic [23:0] c, input logic [5:0] ch);
        bus.preamble           = pre;
        bus.access_address     = aa;
        bus.crc_state_init_bit = c;
        bus.channel_number     = ch;
    endtask

    // inj_kind 1: mid-packet start pulse, buffer write and parameter change; 2: reset.
    task automatic run_packet(input bit pre_started, input int inj_cycle,
                              input int inj_kind, input bit chain_next);
        int k = 0, cyc, done_cyc = -1, t_err = 0, h_err = 0, b_err = 0;
        int last_cnt = 0, last_pos = -1, bit_err = 0, first_bad = -1, dn = 0, vl = 0;
        bit cur = 1'b0;
        int n = exp_q.size();
        int budget = 16 * n + 64;
        string p = $sformatf("pkt%0d", pkt_id);
        pkt_id++;
        got_q.delete();
        if (!pre_started) begin
            @(negedge clk);
            bus.start = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        for (cyc = 1; cyc <= budget; cyc++) begin
            if (bus.done) begin
                done_cyc = cyc;
                chk({p, "_busy_at_done"}, 64'(bus.busy), 64'd0);
                if (chain_next) bus.start = 1'b1;
                break;
            end
            if (!bus.busy) b_err++;
            if (bus.bit_valid) begin
                if (cyc != 1 + 16 * k) t_err++;
                got_q.push_back(bus.bit_out);
                cur = bus.bit_out;
                if (bus.bit_last) begin
                    last_cnt++;
                    last_pos = k;
                end
                k++;
            end else begin
                if (bus.bit_out !== cur) h_err++;
                if (bus.bit_last) last_cnt++;
            end
            if (cyc == inj_cycle && inj_kind == 1) begin
                bus.start = 1'b1;
                bus.pdu_octet_mem_we   = 1'b1;
                bus.pdu_octet_mem_addr = 6'd5;
                bus.pdu_octet_mem_data = 8'h3C;
                set_params(nxt_pre, nxt_aa, nxt_crc, nxt_ch);
            end else if (cyc == inj_cycle && inj_kind == 2) begin
                rst = 1'b1;
                #1;
                chk({p, "_rst_valid"}, 64'(bus.bit_valid), 64'd0);
                chk({p, "_rst_busy"}, 64'(bus.busy), 64'd0);
                chk({p, "_rst_bit_out"}, 64'(bus.bit_out), 64'd0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
                repeat (40) begin
                    @(negedge clk);
                    if (bus.done) dn++;
                    if (bus.bit_valid || bus.busy) vl++;
                end
                chk({p, "_no_done_after_rst"}, 64'(dn), 64'd0);
                chk({p, "_idle_after_rst"}, 64'(vl), 64'd0);
                return;
            end else if (cyc == inj_cycle + 1) begin
                bus.start = 1'b0;
                bus.pdu_octet_mem_we = 1'b0;
            end
            @(negedge clk);
        end
        chk({p, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
        chk({p, "_strobes"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            if (got_q[i] != exp_q[i]) begin
                bit_err++;
                if (first_bad < 0) first_bad = i;
            end
        end
        chk({p, "_bit_errors"}, 64'(bit_err), 64'd0);
        if (bit_err != 0) $display("  %s first differing bit index %0d", p, first_bad);
        chk({p, "_strobe_timing"}, 64'(t_err), 64'd0);
        chk({p, "_bit_hold"}, 64'(h_err), 64'd0);
        chk({p, "_busy_high"}, 64'(b_err), 64'd0);
        chk({p, "_last_count"}, 64'(last_cnt), 64'd1);
        chk({p, "_last_pos"}, 64'(last_pos), 64'(n - 1));
        chk({p, "_done_cycle"}, 64'(done_cyc), 64'(1 + 16 * n));
    endtask

    initial begin
        logic [15:0] head;
        logic [15:0] head_req;
        int vl;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.pdu_octet_mem_we = 1'b0;
        bus.pdu_octet_mem_addr = 6'd0;
        bus.pdu_octet_mem_data = 8'd0;
        set_params(8'd0, 32'd0, 24'd0, 6'd0);
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_valid", 64'(bus.bit_valid), 64'd0);
        chk("reset_bit_out", 64'(bus.bit_out), 64'd0);
        chk("reset_last", 64'(bus.bit_last), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{8'h00, 8'h00, 8'hAA, 32'h8E89BED6, 24'h555555, 6'd37, 80};
        vecs[1] = '{8'h02, 8'h05, 8'h55, 32'h12345678, 24'hABCDEF, 6'd0, 120};
        vecs[2] = '{8'h46, 8'd62, 8'hAA, 32'h50654C54, 24'h000000, 6'd63, 576};
        vecs[3] = '{8'h1F, 8'hFF, 8'h55, 32'hDEADBEEF, 24'hFFFFFF, 6'd12, 576};
        vecs[4] = '{8'h01, 8'h01, 8'hAA, 32'h8E89BED6, 24'h123456, 6'd39, 88};
        for (int v = 0; v < 5; v++) begin
            fill_buffer(vecs[v].hdr0, vecs[v].hdr1);
            set_params(vecs[v].pre, vecs[v].aa, vecs[v].crc, vecs[v].ch);
            build_expected(vecs[v].pre, vecs[v].aa, vecs[v].crc, vecs[v].ch);
            run_packet(1'b0, -10, 0, 1'b0);
            chk($sformatf("vec%0d_bit_count", v), 64'(got_q.size()), 64'(vecs[v].exp_bits));
            if (v == 0) begin
                head = 16'h0000;
                for (int i = 0; i < 16; i++) if (i < got_q.size()) head[i] = got_q[i];
                head_req = 16'hD6AA;
                chk("basic_first16_bits", 64'(head), 64'(head_req));
                chk("whiten_first_pdu_bit", 64'((got_q.size() > 40) ? got_q[40] : 1'b0), 64'd1);
            end
        end

        // Mid-packet start/write/parameter changes must not disturb the packet.
        fill_buffer(8'h0A, 8'd4);
        write_byte(6'd5, 8'hC3);
        set_params(8'($urandom), 32'($urandom), 24'($urandom), 6'($urandom));
        build_expected(bus.preamble, bus.access_address, bus.crc_state_init_bit, bus.channel_number);
        nxt_pre = 8'($urandom);
        nxt_aa  = 32'($urandom);
        nxt_crc = 24'($urandom);
        nxt_ch  = 6'($urandom);
        run_packet(1'b0, 1 + 16 * 20 + 3, 1, 1'b0);
        vl = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.bit_valid || bus.busy || bus.done) vl++;
        end
        chk("no_second_packet", 64'(vl), 64'd0);

        // Packet with the parameters changed mid-flight, then one started on its done cycle.
        build_expected(nxt_pre, nxt_aa, nxt_crc, nxt_ch);
        run_packet(1'b0, -10, 0, 1'b1);
        set_params(8'($urandom), 32'($urandom), 24'($urandom), 6'($urandom));
        build_expected(bus.preamble, bus.access_address, bus.crc_state_init_bit, bus.channel_number);
        run_packet(1'b1, -10, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            fill_buffer(8'($urandom), 8'($urandom_range(0, 80)));
            set_params(8'($urandom), 32'($urandom), 24'($urandom), 6'($urandom));
            build_expected(bus.preamble, bus.access_address, bus.crc_state_init_bit, bus.channel_number);
            run_packet(1'b0, -10, 0, 1'b0);
        end

        // Reset during the PDU field, then a clean packet afterwards.
        fill_buffer(8'h03, 8'd10);
        set_params(8'hAA, 32'($urandom), 24'($urandom), 6'($urandom));
        build_expected(bus.preamble, bus.access_address, bus.crc_state_init_bit, bus.channel_number);
        run_packet(1'b0, 1 + 16 * 60 + 7, 2, 1'b0);
        fill_buffer(8'h07, 8'd6);
        set_params(8'h55, 32'($urandom), 24'($urandom), 6'($urandom));
        build_expected(bus.preamble, bus.access_address, bus.crc_state_init_bit, bus.channel_number);
        run_packet(1'b0, -10, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/btle_tx_pdu_serializer.md
Name: btle_tx_pdu_serializer

Overview:
- Transmit-side consumer of the link layer's TX PDU octet interface.
- The link layer writes PDU octets into this block's 64-octet buffer and pulses start.
- The block then serializes one complete air packet into a timed bit stream for the GFSK modulator: preamble, access address, whitened PDU, whitened CRC24.
- It computes the CRC and whitening on the fly and reports busy/done back to the link layer.

Parameters:
- SAMPLE_PER_SYMBOL, 16, clocks per air bit (16 MHz clk / 1 Mbps).
- CRC_STATE_BIT_WIDTH, 24, CRC LFSR width.
- CHANNEL_NUMBER_BIT_WIDTH, 6, channel index width.
- MAX_PAYLOAD_LEN, 62, clamp on the header length octet so the PDU fits 64 octets.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- preamble  in  8  preamble octet
- access_address  in  32  access address
- crc_state_init_bit  in  24  CRC LFSR initial state
- channel_number  in  6  whitening seed
- pdu_octet_mem_we  in  1  buffer write enable
- pdu_octet_mem_addr  in  6  buffer write address
- pdu_octet_mem_data  in  8  buffer write data
- start  in  1  one-cycle request to send the packet
- busy  out  1  high while a packet is being serialized
- bit_out  out  1  current air bit, held for a full symbol period
- bit_valid  out  1  one-cycle strobe at the first clock of each bit period
- bit_last  out  1  asserted together with bit_valid on the final CRC bit
- done  out  1  one-cycle pulse when the packet is complete

Behaviour:
- Reset: busy, bit_out, bit_valid, bit_last, done all 0; FSM goes to IDLE; buffer contents undefined. Reset mid-packet aborts at once; no done pulse.
- Buffer: 64x8 registers, written on clk when pdu_octet_mem_we=1 and busy=0. Writes while busy are ignored.
- Start acceptance:
  - start is sampled only in IDLE. start while busy is ignored.
  - On acceptance at cycle N, the block latches preamble, access_address, crc_state_init_bit and channel_number.
  - len = min(buf[1], MAX_PAYLOAD_LEN); PDU octet count = 2+len.
  - busy rises at N+1.
- FSM: IDLE -> PREAMBLE (8 bits) -> ACCESS_ADDR (32 bits) -> PDU ((2+len)*8 bits) -> CRC (24 bits) -> IDLE.
- Bit timing:
  - Bit k (0-based) is presented with bit_valid at cycle N+1+k*SPS; bit_out holds it for SPS cycles.
  - After the last bit period ends, done=1 and busy=0 at cycle N+1+total_bits*SPS.
  - A new start is accepted from that same cycle.
- Bit order:
  - Preamble, access address and each PDU octet go LSB first.
  - PDU octets are sent in address order 0..(1+len).
  - CRC goes c[23] first.
- CRC24:
  - c loaded from crc_state_init_bit at start.
  - For each unwhitened PDU bit d: fb=c[23]^d; c <= {c[22:0],fb} ^ (fb ? 24'h00065A : 0).
  - During CRC state, the transmitted raw bit is c[23] and c shifts left by one per bit.
- Whitening:
  - 7-bit LFSR w, initialised to w[6]=1, w[5]=ch[0], w[4]=ch[1] ... w[0]=ch[5].
  - Applies to PDU and CRC bits only: bit_out = raw ^ w[6].
  - After each whitened bit: w_next[0]=w[6], w_next[4]=w[3]^w[6], other w_next[i]=w[i-1].
  - w is not advanced during preamble or access address.
- Length: len=0 is legal (header-only PDU). buf[1] > 62 is clamped to 62.
- Input changes while busy: changes to preamble, access_address, crc_state_init_bit or channel_number have no effect.

Test Plan:
- Basic packet: preamble=0xAA, AA=0x8E89BED6, buf[0]=0x00, buf[1]=0x00, start at cycle N -> exactly 80 bit_valid strobes, 16 cycles apart. First 8 bits are 0,1,0,1,0,1,0,1; bits 8..15 are 0,1,1,0,1,0,1,1. bit_last on strobe 80; done and busy=0 at N+1281.
- Whitening and CRC check: len=0, buf[0]=0x00, crc_init=0x555555, ch=37 -> first PDU bit (bit 40) is 1 (0^w[6]=1). The 24 de-whitened CRC bits match the golden model's CRC over 16 zero bits.
- Length clamp: buf[1]=0xFF -> 8+32+64*8+24=576 bits; the last PDU octet is read from address 63.
- Ignored inputs while busy: start pulse and buffer writes (addr 5, data 0x3C) mid-packet -> stream unchanged, no second packet. Buffer addr 5 still holds its old value on the next packet.
- Back-to-back packets: start asserted in the same cycle as done -> second packet's first bit_valid one cycle later, with no gap beyond that.
- Reset mid-packet: rst asserted during PDU state -> bit_valid, busy and bit_out go 0 immediately, no done pulse. After release, a fresh start sends a correct complete packet.
